// File: rtl/uart_msg_scheduler.sv
// Round-robin arbiter + code FIFO feeding the single UART TX over a 4-phase req/ack,
// with duplicate/zero filtering, post-message pacing and a terminal STOP code.
`timescale 1ns/1ps
module uart_msg_scheduler #(
    parameter int         NREQ       = 3,
    parameter int         FIFO_DEPTH = 8,
    parameter int         GAP_CYCLES = 60000,
    parameter logic [4:0] STOP_CODE  = 5'd31
) (
    input  logic                          clk_50M,
    input  logic                          rst_n,
    input  logic [NREQ-1:0]               src_req,
    input  logic [5*NREQ-1:0]             src_code,
    output logic [NREQ-1:0]               src_ack,
    output logic                          tx_req,
    output logic [4:0]                    tx_code,
    input  logic                          tx_ack,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [7:0]                    drop_cnt,
    output logic                          done
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_REL, S_GAP} state_t;

    state_t          r_state, w_state_nxt;
    logic            r_ack_meta, r_ack_s;
    logic [NREQ-1:0] r_src_ack;
    logic [PW-1:0]   r_rr_ptr;
    logic            r_gnt_vld;
    logic [4:0]      r_gnt_code;
    logic [4:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wptr, r_rptr;
    logic [CW-1:0]   r_count;
    logic [4:0]      r_tx_code, r_last_code;
    logic            r_tx_req, r_done;
    logic [7:0]      r_drop_cnt;
    logic [GW-1:0]   r_gap;

    logic [4:0]      w_codes [NREQ];
    logic [NREQ-1:0] w_elig, w_gnt_1h;
    logic            w_block, w_gnt_vld;
    logic [PW-1:0]   w_gnt_idx;
    int              w_idx;
    logic            w_push, w_late_drop, w_pop, w_dup, w_issue;
    logic [4:0]      w_head;
    logic [8:0]      w_drop_sum;

    for (genvar g = 0; g < NREQ; g++) begin : g_code
        assign w_codes[g] = src_code[5*g +: 5];
    end

    assign w_elig   = src_req & ~r_src_ack;
    // A grant already in the push stage counts as occupied so the FIFO can never overflow.
    assign w_block  = ({1'b0, r_count} + {{CW{1'b0}}, r_gnt_vld}) >= (CW+1)'(FIFO_DEPTH);

    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= NREQ) w_idx = w_idx - NREQ;
            if (!w_gnt_vld && !w_block && w_elig[PW'(w_idx)]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = PW'(w_idx);
            end
        end
    end

    assign w_gnt_1h    = w_gnt_vld ? (NREQ'(1) << w_gnt_idx) : '0;
    assign w_push      = r_gnt_vld && !r_done && (r_gnt_code != 5'd0);
    assign w_late_drop = r_gnt_vld && r_done;
    assign w_head      = r_mem[r_rptr];
    assign w_issue     = w_pop && !w_dup;
    assign w_drop_sum  = {1'b0, r_drop_cnt} + {8'd0, w_late_drop} + {8'd0, w_dup};

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_dup       = 1'b0;
        case (r_state)
            S_IDLE: if (r_count != '0 && !r_ack_s) begin
                w_pop = 1'b1;
                if (w_head == r_last_code) w_dup = 1'b1;
                else                       w_state_nxt = S_REQ;
            end
            S_REQ:  if (r_ack_s)        w_state_nxt = S_REL;
            S_REL:  if (!r_ack_s)       w_state_nxt = S_GAP;
            S_GAP:  if (r_gap == '0)    w_state_nxt = S_IDLE;
            default:                    w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_50M) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            // Synchronizer resets high so a TX ack still held across reset is honoured.
            r_ack_meta <= 1'b1;
            r_ack_s    <= 1'b1;
            r_src_ack  <= '0;
            r_rr_ptr   <= '0;
            r_gnt_vld  <= 1'b0;
            r_gnt_code <= 5'd0;
        end else begin
            r_ack_meta <= tx_ack;
            r_ack_s    <= r_ack_meta;
            r_src_ack  <= (r_src_ack & src_req) | w_gnt_1h;
            r_gnt_vld  <= w_gnt_vld;
            r_gnt_code <= w_codes[w_gnt_idx];
            if (w_gnt_vld)
                r_rr_ptr <= (w_gnt_idx == PW'(NREQ-1)) ? '0 : w_gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk_50M) begin
        if (w_push) r_mem[r_wptr] <= r_gnt_code;
    end

    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_tx_req    <= 1'b0;
            r_tx_code   <= 5'd0;
            r_last_code <= 5'd0;
            r_done      <= 1'b0;
            r_drop_cnt  <= 8'd0;
            r_gap       <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_drop_cnt <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
            if (w_issue) begin
                r_tx_req    <= 1'b1;
                r_tx_code   <= w_head;
                r_last_code <= w_head;
            end
            if (r_state == S_REQ && r_ack_s) r_tx_req <= 1'b0;
            if (r_state == S_REL && !r_ack_s) begin
                r_gap <= GW'(GAP_CYCLES - 1);
                if (r_tx_code == STOP_CODE) r_done <= 1'b1;
            end else if (r_state == S_GAP && r_gap != '0) begin
                r_gap <= r_gap - 1'b1;
            end
        end
    end

    assign src_ack    = r_src_ack;
    assign tx_req     = r_tx_req;
    assign tx_code    = r_tx_code;
    assign fifo_count = r_count;
    assign drop_cnt   = r_drop_cnt;
    assign done       = r_done;
endmodule
